pipe_valid_chain: RTL and testbench

//  Parametrised N-stage in-order pipeline control + payload chain, valid/allowin handshake.

---
 rtl/pipe_valid_chain_pkg.sv | 18 +
 rtl/pipe_valid_chain_stage_reg.sv | 56 +++++
 rtl/pipe_valid_chain.sv | 129 ++++++++++++
 tb/tb_pipe_valid_chain.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_valid_chain_pkg.sv
// Shared constants for the in-order pipeline valid/allowin chain.
// Holds the default stage count and payload width used by the CPU top,
// and symbolic stage indices for the 5-stage core.
package pipe_valid_chain_pkg;

    localparam int PIPE_DEF_STAGES = 5;
    localparam int PIPE_DEF_DATA_W = 64;
    localparam int PIPE_DEF_CNT_W  = 32;

    typedef enum logic [2:0] {
        STAGE_IF  = 3'd0,
        STAGE_ID  = 3'd1,
        STAGE_EX  = 3'd2,
        STAGE_MEM = 3'd3,
        STAGE_WB  = 3'd4
    } stageIdx_e;

endpackage

// File: rtl/pipe_valid_chain_stage_reg.sv
// One pipeline stage: a valid bit plus a payload register.
// A kill clears the entry regardless of stalls; otherwise the stage loads the
// incoming entry when it allows in, dropping it if the source stage was killed.
module pipe_stage_reg
    import pipe_valid_chain_pkg::*;
#(
    parameter int DATA_W = PIPE_DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              allowIn_i,
    input  logic              kill_i,
    input  logic              drop_i,
    input  logic              incoming_i,
    input  logic [DATA_W-1:0] incomingData_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next-state: kill beats everything, then advance when allowed, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (kill_i) begin
            valid_d = 1'b0;
        end else if (allowIn_i) begin
            valid_d = incoming_i && !drop_i;
            if (incoming_i) begin
                data_d = incomingData_i;
            end
        end
    end

    // Valid bit is the only state that needs a reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is don't-care while invalid, so it is left unreset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_valid_chain.sv
// N-stage in-order pipeline control and payload chain with valid/allowin
// handshake, per-stage ready_go stalls and flush-based kill of younger stages.
// Define PIPE_PERF_CNT_EN to build the saturating retire/stall/flush counters;
// without it the perf_* ports are tied to zero.
module pipe_valid_chain
    import pipe_valid_chain_pkg::*;
#(
    parameter int NUM_STAGES = PIPE_DEF_STAGES,
    parameter int DATA_W     = PIPE_DEF_DATA_W,
    parameter int CNT_W      = PIPE_DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_allowin,
    input  logic [NUM_STAGES-1:0]        stage_ready_go,
    input  logic [NUM_STAGES-1:0]        flush,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0] stage_data,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic [CNT_W-1:0]             perf_retire_cnt,
    output logic [CNT_W-1:0]             perf_stall_cnt,
    output logic [CNT_W-1:0]             perf_flush_cnt
);

    logic [NUM_STAGES:0]                    allowIn;
    logic [NUM_STAGES-1:0]                  killVec;
    logic [NUM_STAGES-1:0]                  dropVec;
    logic [NUM_STAGES-1:0]                  incomingVec;
    logic [NUM_STAGES-1:0]                  validVec;
    logic [NUM_STAGES-1:0][DATA_W-1:0]      dataVec;
    logic [NUM_STAGES-1:0][DATA_W-1:0]      prevData;

    // Allowin ripples from the sink back to stage 0; kill ranges spread from
    // the oldest flushing stage down to stage 0.
    always_comb begin
        allowIn     = '0;
        killVec     = '0;
        dropVec     = '0;
        incomingVec = '0;
        allowIn[NUM_STAGES] = out_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            allowIn[k] = !validVec[k] || (stage_ready_go[k] && allowIn[k+1]);
        end
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            killVec[k] = killVec[k+1] | flush[k+1];
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            dropVec[k]     = killVec[k-1];
            incomingVec[k] = validVec[k-1] && stage_ready_go[k-1];
        end
        incomingVec[0] = in_valid && allowIn[0] && !killVec[0];
    end

    assign in_allowin = allowIn[0] && !killVec[0];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : gStage
        if (k == 0) begin : gFirst
            assign prevData[k] = in_data;
        end else begin : gRest
            assign prevData[k] = dataVec[k-1];
        end

        pipe_stage_reg #(
            .DATA_W(DATA_W)
        ) uStage (
            .clk           (clk),
            .reset         (reset),
            .allowIn_i     (allowIn[k]),
            .kill_i        (killVec[k]),
            .drop_i        (dropVec[k]),
            .incoming_i    (incomingVec[k]),
            .incomingData_i(prevData[k]),
            .valid_o       (validVec[k]),
            .data_o        (dataVec[k])
        );
    end

    assign stage_valid = validVec;
    assign stage_data  = dataVec;
    assign out_valid   = validVec[NUM_STAGES-1] && stage_ready_go[NUM_STAGES-1];
    assign out_data    = dataVec[NUM_STAGES-1];

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] retireCnt_q;
    logic [CNT_W-1:0] stallCnt_q;
    logic [CNT_W-1:0] flushCnt_q;
    logic             retireFire;
    logic             stallCycle;
    logic             flushCycle;

    assign retireFire = out_valid && out_ready;
    assign stallCycle = in_valid && !in_allowin;
    assign flushCycle = |flush;

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retireCnt_q <= '0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
        end else begin
            if (retireFire && (retireCnt_q != '1)) begin
                retireCnt_q <= retireCnt_q + CNT_ONE;
            end
            if (stallCycle && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + CNT_ONE;
            end
            if (flushCycle && (flushCnt_q != '1)) begin
                flushCnt_q <= flushCnt_q + CNT_ONE;
            end
        end
    end

    assign perf_retire_cnt = retireCnt_q;
    assign perf_stall_cnt  = stallCnt_q;
    assign perf_flush_cnt  = flushCnt_q;
`else
    assign perf_retire_cnt = '0;
    assign perf_stall_cnt  = '0;
    assign perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_valid_chain.sv
// Scoreboard bench for pipe_valid_chain: entries are tracked as an ordered
// list with a stage position each; retirements are popped and checked by a
// separate monitor process.
module tb_pipe_valid_chain;
    import pipe_valid_chain_pkg::*;

    localparam int NS = 5;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        bit            lat;
    } ent_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [DW-1:0]      in_data;
    logic               in_allowin;
    logic [NS-1:0]      stage_ready_go;
    logic [NS-1:0]      flush;
    logic [NS-1:0]      stage_valid;
    logic [NS*DW-1:0]   stage_data;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_ready;
    logic [CW-1:0]      perf_retire_cnt;
    logic [CW-1:0]      perf_stall_cnt;
    logic [CW-1:0]      perf_flush_cnt;

    ent_t exp[$];
    int   pos[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cycleCount = 0;
    bit   fullFlow = 1'b0;
    int   mRetire = 0;
    int   mStall = 0;
    int   mFlush = 0;

    pipe_valid_chain #(.NUM_STAGES(NS), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_allowin     (in_allowin),
        .stage_ready_go (stage_ready_go),
        .flush          (flush),
        .stage_valid    (stage_valid),
        .stage_data     (stage_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .perf_retire_cnt(perf_retire_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    // Cycle index used for latency bookkeeping.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    function automatic int satInc(input int x);
        return (x == CNT_MAX) ? x : x + 1;
    endfunction

    task automatic checkCounters();
        checkOutput("perf_retire_cnt", perf_retire_cnt, PERF_EN ? mRetire : 0);
        checkOutput("perf_stall_cnt", perf_stall_cnt, PERF_EN ? mStall : 0);
        checkOutput("perf_flush_cnt", perf_flush_cnt, PERF_EN ? mFlush : 0);
    endtask

    // One cycle: drive inputs, check against the entry-list model, then move
    // the model's entries forward the way the pipeline rules dictate.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [NS-1:0] rg,
                                 input logic [NS-1:0] fl, input logic ordy);
        logic [NS-1:0] occ;
        bit            mv[$];
        int            newPos[$];
        int            killFrom;
        int            nKill;
        bit            expAllow;
        bit            expOutValid;
        bit            m;
        @(negedge clk);
        in_valid = v;
        in_data = d;
        stage_ready_go = rg;
        flush = fl;
        out_ready = ordy;
        #1;
        checkCounters();
        occ = '0;
        foreach (pos[i]) occ[pos[i]] = 1'b1;
        checkOutput("stage_valid", stage_valid, occ);
        if (pos.size() == exp.size()) begin
            foreach (pos[i]) checkOutput("stage_data", stage_data[pos[i]*DW +: DW], exp[i].data);
        end
        killFrom = 0;
        for (int j = 1; j < NS; j++) if (fl[j]) killFrom = j;
        mv = {};
        for (int i = 0; i < pos.size(); i++) begin
            if (pos[i] == NS - 1) m = rg[NS-1] && ordy;
            else m = rg[pos[i]] && (i == 0 || pos[i-1] != pos[i] + 1 || mv[i-1]);
            mv.push_back(m);
        end
        expAllow = (killFrom == 0);
        if (occ[0] && !mv[pos.size()-1]) expAllow = 1'b0;
        expOutValid = occ[NS-1] && rg[NS-1];
        checkOutput("in_allowin", in_allowin, expAllow);
        checkOutput("out_valid", out_valid, expOutValid);
        if (v && !expAllow) mStall = satInc(mStall);
        if (|fl) mFlush = satInc(mFlush);
        if (expOutValid && ordy) mRetire = satInc(mRetire);
        nKill = 0;
        newPos = {};
        for (int i = 0; i < pos.size(); i++) begin
            if (pos[i] < killFrom) nKill++;
            else if (mv[i]) begin
                if (pos[i] != NS - 1) newPos.push_back(pos[i] + 1);
            end else newPos.push_back(pos[i]);
        end
        repeat (nKill) if (exp.size() > 0) void'(exp.pop_back());
        if (v && expAllow) begin
            newPos.push_back(0);
            exp.push_back('{data: d, cyc: cycleCount, lat: fullFlow});
        end
        pos = newPos;
    endtask

    // Asynchronous reset asserted mid-cycle; entries must vanish immediately.
    task automatic doReset();
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("reset_stage_valid", stage_valid, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        exp = {};
        pos = {};
        mRetire = 0;
        mStall = 0;
        mFlush = 0;
        in_valid = 1'b0;
        flush = '0;
        stage_ready_go = '1;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_in_allowin", in_allowin, 1);
        checkCounters();
    endtask

    // Monitor: whenever the DUT retires, pop and compare the oldest entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                if (exp.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL retire_order: got retire of %0h, expected no retire", out_data);
                end else begin
                    e = exp.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    if (e.lat) checkOutput("latency", cycleCount, e.cyc + NS);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NS-1:0] rg;
        logic [NS-1:0] fl;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        stage_ready_go = '1;
        flush = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_stage_valid", stage_valid, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkCounters();
        reset = 1'b0;
        #1;
        checkOutput("post_reset_in_allowin", in_allowin, 1);

        $display("[TB] full-flow latency and order");
        fullFlow = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(i), '1, '0, 1'b1);
        fullFlow = 1'b0;
        repeat (7) applyStimulus(1'b0, '0, '1, '0, 1'b1);

        $display("[TB] mid-pipe stall");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, DW'(16'h100 + i), '1, '0, 1'b1);
        rg = '1;
        rg[STAGE_EX] = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(16'h200 + i), rg, '0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(16'h210 + i), '1, '0, 1'b1);
        repeat (7) applyStimulus(1'b0, '0, '1, '0, 1'b1);

        $display("[TB] single flush");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(16'hA + i), '1, '0, 1'b0);
        fl = '0;
        fl[STAGE_MEM] = 1'b1;
        applyStimulus(1'b1, DW'(16'h0F), '1, fl, 1'b1);
        repeat (6) applyStimulus(1'b0, '0, '1, '0, 1'b1);

        $display("[TB] dual flush with stall");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(16'h400 + i), '1, '0, 1'b0);
        rg = '1;
        rg[STAGE_IF] = 1'b0;
        fl = '0;
        fl[STAGE_ID] = 1'b1;
        fl[STAGE_WB] = 1'b1;
        applyStimulus(1'b1, DW'(16'h55), rg, fl, 1'b1);
        applyStimulus(1'b1, DW'(16'h56), '1, '0, 1'b1);
        repeat (6) applyStimulus(1'b0, '0, '1, '0, 1'b1);

        $display("[TB] backpressure and counter saturation");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(16'h300 + i), '1, '0, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, DW'(16'h320 + i), '1, '0, 1'b0);
        repeat (7) applyStimulus(1'b0, '0, '1, '0, 1'b1);

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(16'h500 + i), '1, '0, 1'b1);
        doReset();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NS; k++) begin
                rg[k] = ($urandom_range(0, 99) < 85);
                fl[k] = ($urandom_range(0, 99) < 4);
            end
            applyStimulus($urandom_range(0, 99) < 75, DW'($urandom), rg, fl, $urandom_range(0, 99) < 80);
        end
        repeat (8) applyStimulus(1'b0, '0, '1, '0, 1'b1);
        @(negedge clk);
        #3;
        checkOutput("drain_empty", exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
